// File: rtl/debug_probe_display.sv
// Debug front end: debounced step/select buttons plus a paged 7-segment view of probe buses.
// Optional feature macro AUTO_SCROLL_EN adds a periodic view-advance timer.

module debug_probe_btn #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    localparam int unsigned CW = $clog2(DB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Synchronise, require DB_CYCLES consecutive mismatching cycles, pulse on accepted rise
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            pulse   <= level & ~level_d;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module debug_probe_display #(
    parameter int unsigned NCH          = 4,
    parameter int unsigned PW           = 32,
    parameter int unsigned DB_CYCLES    = 1000000,
    parameter int unsigned REFRESH_BITS = 17,
    parameter int unsigned SCROLL_BITS  = 27,
    localparam int unsigned NPG         = PW / 16,
    localparam int unsigned CHW         = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned PGW         = (NPG > 1) ? $clog2(NPG) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_step,
    input  logic              btn_sel,
    input  logic [NCH*PW-1:0] probes,
    output logic              step_pulse,
    output logic [CHW-1:0]    ch_sel,
    output logic [PGW-1:0]    page_sel,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp
);
    localparam int unsigned NVIEW = NCH * NPG;
    localparam int unsigned VW    = (NVIEW > 1) ? $clog2(NVIEW) : 1;

    if (NCH < 1 || PW < 16 || (PW % 16) != 0 || DB_CYCLES < 2 ||
        REFRESH_BITS < 2 || SCROLL_BITS < 1) begin : g_bad_params
        $error("debug_probe_display: illegal parameter combination");
    end

    logic                    sel_pulse;
    logic                    advance;
    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              slot;
    logic [VW-1:0]           vidx;
    logic [15:0]             win;
    logic [3:0]              nib;
    logic [15:0]             views [NVIEW];

    debug_probe_btn #(.DB_CYCLES(DB_CYCLES)) u_step (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_step),
        .pulse (step_pulse)
    );

    debug_probe_btn #(.DB_CYCLES(DB_CYCLES)) u_sel (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_sel),
        .pulse (sel_pulse)
    );

`ifdef AUTO_SCROLL_EN
    logic [SCROLL_BITS-1:0] scroll_cnt;

    // Free-running scroll timer; a manual select restarts the period
    always_ff @(posedge clk) begin
        if (reset || sel_pulse) begin
            scroll_cnt <= '0;
        end else begin
            scroll_cnt <= scroll_cnt + SCROLL_BITS'(1);
        end
    end

    assign advance = sel_pulse | (&scroll_cnt);
`else
    assign advance = sel_pulse;
`endif

    // View index walks pages within a channel, then moves to the next channel
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_sel   <= '0;
            page_sel <= '0;
        end else if (advance) begin
            if (page_sel == PGW'(NPG - 1)) begin
                page_sel <= '0;
                ch_sel   <= (ch_sel == CHW'(NCH - 1)) ? '0 : ch_sel + CHW'(1);
            end else begin
                page_sel <= page_sel + PGW'(1);
            end
        end
    end

    // Channel k page j sits at probes[(k*NPG + j)*16 +: 16]
    for (genvar k = 0; k < int'(NVIEW); k++) begin : g_view
        assign views[k] = probes[k*16 +: 16];
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        slot = refresh[REFRESH_BITS-1 -: 2];
        vidx = VW'(int'(ch_sel) * int'(NPG) + int'(page_sel));
        win  = views[vidx];
        nib  = win[{slot, 2'b00} +: 4];
    end

    // Digit scan; outputs lag the slot change by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh <= '0;
            an      <= 4'b1111;
            seg     <= 7'b1111111;
            dp      <= 1'b1;
        end else begin
            refresh <= refresh + REFRESH_BITS'(1);
            an      <= ~(4'b0001 << slot);
            seg     <= hex7(nib);
            dp      <= !((slot == 2'd3) && page_sel[0]);
        end
    end
endmodule
